// File: rtl/alu_issue_stage.sv
// Issue/return stage around the external 4-bit combinational ALU.
// Requests queue in a small FIFO, execute one at a time, and results are held until the consumer takes them.
module alu_issue_stage #(
  parameter int N     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [3:0]   in_sel,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_select,
  input  logic [N-1:0] alu_out,
  input  logic         alu_cout,
  input  logic         alu_neg,
  input  logic         alu_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_cout,
  output logic         out_neg,
  output logic         out_zero,
  output logic [3:0]   out_sel,
  output logic         out_illegal,
  output logic         busy
);

  // state | meaning
  // IDLE  | no operation in flight; pops the FIFO head when one is present
  // EXEC  | operand register drives the ALU; result captured at the end of this cycle
  // HOLD  | result presented downstream until out_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]  fifo_a_q   [DEPTH];
  logic [N-1:0]  fifo_b_q   [DEPTH];
  logic [3:0]    fifo_sel_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  op_a_q, op_b_q;
  logic [3:0]    op_sel_q;

  logic          push, pop, capture, illegal;

  assign in_ready = (count_q < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign illegal  = (op_sel_q > 4'd10);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        capture = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read once count says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q]   <= in_a;
      fifo_b_q[wr_ptr_q]   <= in_b;
      fifo_sel_q[wr_ptr_q] <= in_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      out_result  <= '0;
      out_cout    <= 1'b0;
      out_neg     <= 1'b0;
      out_zero    <= 1'b0;
      out_sel     <= '0;
      out_illegal <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        op_a_q   <= fifo_a_q[rd_ptr_q];
        op_b_q   <= fifo_b_q[rd_ptr_q];
        op_sel_q <= fifo_sel_q[rd_ptr_q];
      end
      // Undefined select codes return a clean all-zero result tagged illegal.
      if (capture) begin
        out_result  <= illegal ? '0 : alu_out;
        out_cout    <= !illegal && alu_cout;
        out_neg     <= !illegal && alu_neg;
        out_zero    <= !illegal && alu_zero;
        out_sel     <= op_sel_q;
        out_illegal <= illegal;
      end
    end
  end

  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_select = op_sel_q;
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU hooked to its alu_* ports.
module tb_alu_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_a, in_b, in_sel, alu_a, alu_b, alu_select, alu_out;
  logic       alu_cout, alu_neg, alu_zero;
  logic [3:0] out_result, out_sel;
  logic       out_cout, out_neg, out_zero, out_illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(.N(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_neg(out_neg), .out_zero(out_zero),
    .out_sel(out_sel), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU stand-in; undefined codes return all-ones with carry so masking is visible.
  logic [4:0] alu_t;
  always_comb begin
    alu_t = 5'd0;
    case (alu_select)
      4'd0:    alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1:    alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2:    alu_t = {1'b0, alu_a & alu_b};
      4'd3:    alu_t = {1'b0, alu_a | alu_b};
      4'd8:    alu_t = {1'b0, alu_a ^ alu_b};
      4'd9:    alu_t = {1'b0, ~alu_a};
      4'd10:   alu_t = {1'b0, alu_b};
      default: alu_t = 5'b11111;
    endcase
  end
  assign alu_out  = alu_t[3:0];
  assign alu_cout = alu_t[4];
  assign alu_neg  = alu_t[3];
  assign alu_zero = (alu_t[3:0] == 4'd0);

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a, b, sel, res;
    logic       c, n, z, ill;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, idx, n;
    logic rdy;
    logic [3:0] bp_a [4];
    logic [3:0] bp_b [4];
    logic [3:0] bp_s [4];
    logic [3:0] bp_r [3];
    int         b2b_v [6];
    int         b2b_r [6];

    vecs[0] = '{4'h9, 4'h5, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h9, 4'h5, 4'h3, 4'hD, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'h9, 4'h5, 4'h8, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'h3, 4'h1, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'hC, 4'hC, 4'h0, 4'h8, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'h5, 4'h9, 4'h1, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{4'h6, 4'h3, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'hF, 4'h0, 4'hB, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{4'h7, 4'h7, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0};

    in_valid = 0; in_a = 0; in_b = 0; in_sel = 0; out_ready = 0; rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst out_result", out_result, 0);
    chk("rst flags", {out_cout, out_neg, out_zero, out_illegal}, 0);
    chk("rst out_sel", out_sel, 0);
    chk("rst alu ports", {alu_a, alu_b, alu_select}, 0);
    rst_n = 1;
    @(negedge clk);

    // Single operations, one at a time, consumer always ready.
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_a = vecs[i].a; in_b = vecs[i].b; in_sel = vecs[i].sel;
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 0;
      chk($sformatf("v%0d valid+1", i), out_valid, 0);
      chk($sformatf("v%0d busy+1", i), busy, 1);
      @(negedge clk);
      chk($sformatf("v%0d alu ports", i), {alu_a, alu_b, alu_select}, {vecs[i].a, vecs[i].b, vecs[i].sel});
      chk($sformatf("v%0d valid+2", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d valid", i), out_valid, 1);
      chk($sformatf("v%0d result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d cout", i), out_cout, vecs[i].c);
      chk($sformatf("v%0d neg", i), out_neg, vecs[i].n);
      chk($sformatf("v%0d zero", i), out_zero, vecs[i].z);
      chk($sformatf("v%0d sel", i), out_sel, vecs[i].sel);
      chk($sformatf("v%0d illegal", i), out_illegal, vecs[i].ill);
      @(negedge clk);
      chk($sformatf("v%0d valid after", i), out_valid, 0);
      chk($sformatf("v%0d idle", i), busy, 0);
    end

    // Back-to-back requests: results alternate with idle cycles.
    b2b_v = '{0, 0, 1, 0, 1, 0};
    b2b_r = '{0, 0, 13, 0, 12, 0};
    in_valid = 1; in_a = 4'h9; in_b = 4'h5; in_sel = 4'h3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) in_sel = 4'h8;
      else in_valid = 0;
      chk($sformatf("b2b valid c%0d", c), out_valid, b2b_v[c]);
      if (b2b_v[c] == 1) chk($sformatf("b2b result c%0d", c), out_result, b2b_r[c]);
    end
    chk("b2b idle", busy, 0);

    // Backpressure: four offered, three fit (one held, two queued).
    bp_a = '{4'h1, 4'h4, 4'h8, 4'hF};
    bp_b = '{4'h2, 4'h4, 4'h1, 4'hF};
    bp_s = '{4'h0, 4'h0, 4'h2, 4'h8};
    bp_r = '{4'h3, 4'h8, 4'h0};
    out_ready = 0; acc = 0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; in_a = bp_a[idx]; in_b = bp_b[idx]; in_sel = bp_s[idx];
      rdy = in_ready;
      @(negedge clk);
      if (rdy) begin
        acc++;
        if (idx < 3) idx++;
      end
    end
    in_valid = 0;
    chk("bp accepted", acc, 3);
    chk("bp in_ready", in_ready, 0);
    chk("bp valid", out_valid, 1);
    chk("bp first", out_result, bp_r[0]);
    repeat (3) @(negedge clk);
    chk("bp frozen valid", out_valid, 1);
    chk("bp frozen result", out_result, bp_r[0]);
    out_ready = 1; n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (out_valid) begin
        chk($sformatf("bp drain %0d", n), out_result, bp_r[n]);
        n++;
      end
      @(negedge clk);
    end
    chk("bp drained", n, 3);
    chk("bp idle", busy, 0);

    // Reset during EXEC with further work queued.
    out_ready = 0;
    in_valid = 1; in_a = 4'h6; in_b = 4'h6; in_sel = 4'h0;
    repeat (4) @(negedge clk);
    in_valid = 0;
    chk("mid hold", out_valid, 1);
    chk("mid full", in_ready, 0);
    out_ready = 1;
    @(negedge clk);
    chk("mid exec valid", out_valid, 0);
    chk("mid exec busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid rst valid", out_valid, 0);
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst busy", busy, 0);
    chk("mid rst result", out_result, 0);
    chk("mid rst alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post rst valid c%0d", c), out_valid, 0);
      chk($sformatf("post rst busy c%0d", c), busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Sequential front/back end for the 4-bit combinational ALU.
- Accepts operation requests ({a, b, select}) over a valid/ready handshake and buffers them in a small FIFO.
- Drives one operation at a time into the ALU and registers the ALU result and flags.
- Presents the registered result downstream over a second valid/ready handshake.
- Sits between the instruction/operand source and the ALU, and between the ALU and the consumer of its results.

## Interface
Parameters:
- N, 4, operand/result width (matches ALU width)
- DEPTH, 2, request FIFO depth; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request FIFO can accept
- in_a  in  N  operand a
- in_b  in  N  operand b
- in_sel  in  4  ALU select code
- alu_a  out  N  to ALU a
- alu_b  out  N  to ALU b
- alu_select  out  4  to ALU select
- alu_out  in  N  from ALU outMux
- alu_cout  in  1  from ALU Cout
- alu_neg  in  1  from ALU NegFlag
- alu_zero  in  1  from ALU zeroFlag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  N  registered result
- out_cout, out_neg, out_zero  out  1 each  registered flags
- out_sel  out  4  select code of the returned result
- out_illegal  out  1  select code was outside 4'b0000–4'b1010
- busy  out  1  FSM not IDLE, or FIFO not empty

## Operation
- **FIFO:** DEPTH entries of {a, b, sel}.
  - Push when in_valid && in_ready.
  - in_ready = (count < DEPTH); no same-cycle pass-through when full.
  - Simultaneous push and pop: count unchanged; read and write pointers wrap modulo DEPTH.
- **FSM states:** IDLE, EXEC, HOLD.
  - IDLE: if FIFO non-empty, pop the head into the operand register and go to EXEC; otherwise stay.
  - EXEC: the operand register drives alu_a/alu_b/alu_select. At the clock edge, capture alu_out, alu_cout, alu_neg, alu_zero and the select into the output register, then go to HOLD.
  - HOLD: out_valid = 1. On out_ready:
    - if the FIFO is non-empty, pop into the operand register and go to EXEC;
    - otherwise go to IDLE.
    - Without out_ready, stay; all outputs remain stable.
- **Illegal select (4'b1011–4'b1111):** still sequenced through EXEC, but captured as out_result = 0, all flags = 0, out_illegal = 1. For a legal select, out_illegal = 0 and ALU values pass through unmodified.
- alu_* outputs hold the last operand register value outside EXEC.
- **Reset** (asserted at any time, including mid-EXEC or mid-HOLD):
  - FIFO emptied; in-flight operation discarded.
  - FSM to IDLE.
  - All outputs to reset values.

## Timing
- **Reset values:** in_ready = 1, out_valid = 0, busy = 0. out_result, flags, out_sel, out_illegal, alu_a, alu_b, alu_select all = 0.
- **Latency, empty and idle:** request accepted at edge k → FIFO count 1 after k → pop/EXEC at edge k+1 → result captured at edge k+2 → out_valid high after k+2. Accept-to-valid is 2 cycles.
- **Throughput:** with out_ready held high and the FIFO non-empty, one result every 2 cycles (HOLD → EXEC → HOLD).
- **Output handshake:** out_valid never drops without a handshake. The output register changes only at an EXEC capture edge.
- **Combinational paths:** in_ready depends only on registered count. There is no combinational path from in_* or out_ready to any output.
- **ALU capture:** the ALU must settle within one clk period; the capture edge is the end of EXEC.

## Test plan
- Reset, then a=4'b1001, b=4'b0101, sel=4'b0000, out_ready=1 → 2 cycles after acceptance: out_valid=1, out_result=4'b1110, out_sel=0, out_illegal=0.
- Back-to-back: (9,5,sel 4'b0011) then (9,5,sel 4'b1000) → results 4'b1101 then 4'b1100, in order, out_valid high on alternate cycles.
- Backpressure: out_ready=0, offer 4 requests → 3 accepted (1 in HOLD, 2 in FIFO), in_ready=0, out_result frozen. Release out_ready → remaining results drain in order, then busy=0.
- Illegal select: a=4'b0011, b=4'b0001, sel=4'b1100 → out_result=0, flags 0, out_illegal=1, out_sel=4'b1100. The following legal op has out_illegal=0.
- Zero/carry pass-through: a=4'b1100, b=4'b1100, sel=4'b0000 → out_result=4'b1000, out_cout equals the ALU Cout. a=b=0, sel=4'b0000 → out_result=0, out_zero equals the ALU zeroFlag.
- Reset mid-operation: assert rst_n=0 during EXEC with 2 FIFO entries queued → immediately out_valid=0, in_ready=1, busy=0. After release, no stale result appears.
